ysyx_22051145_wb_arbiter: RTL and testbench
===========================================

// Module: ysyx_22051145_wb_arbiter
// PURPOSE
//  Shares the single GPR write port of ysyx_22051145_regfile between NREQ writeback sources
//  (ALU, LSU, CSR) with round-robin arbitration and valid/ready handshakes, one write per cycle.
//  Keeps a 32-entry pending-write scoreboard so decode stalls on RAW hazards until writeback.
//  Sits between the writeback sources and the regfile write port (en_w/waddr/w_data).
// PARAMETERS
//  NREQ  3   number of writeback requesters (2..8)
//  XLEN  64  data width
//  AW    5   register address width (32 GPRs)
// PORTS
//  clk          in   1          clock, all state updates on rising edge
//  rst          in   1          synchronous, active-low reset (0 = reset)
//  req_valid    in   NREQ       requester i has a write pending
//  req_addr     in   NREQ*AW    dest reg of requester i, slice [i*AW +: AW]
//  req_data     in   NREQ*XLEN  write data of requester i, slice [i*XLEN +: XLEN]
//  req_ready    out  NREQ       one-hot grant; transfer when valid & ready
//  rf_en_w      out  1          to regfile en_w
//  rf_waddr     out  AW         to regfile waddr
//  rf_wdata     out  XLEN       to regfile w_data
//  sb_set_en    in   1          decode issued an instruction writing sb_set_addr
//  sb_set_addr  in   AW         destination register being issued
//  rd_addr1     in   AW         decode read address 1
//  rd_addr2     in   AW         decode read address 2
//  rd_hazard    out  2          bit k: rd_addrk has an outstanding write
//  pending      out  32         scoreboard bitmap, bit 0 always 0
// BEHAVIOUR
//  Reset (rst==0 at edge): rf_en_w=0, rf_waddr=0, rf_wdata=0, rr_ptr=0, pending=0; req_ready=0 while rst==0.
//  Arbitration (combinational): search from rr_ptr upward mod NREQ; first valid index g gets req_ready[g]=1.
//   No valid -> req_ready all 0. req_ready never depends on downstream (write port never backpressures).
//  Pointer: after a transfer by g, rr_ptr <= (g+1) mod NREQ; no transfer -> rr_ptr holds.
//  Output stage registered: transfer in cycle t -> rf_en_w=1, rf_waddr/rf_wdata = granted addr/data in t+1.
//   Latency exactly 1 cycle; back-to-back transfers give rf_en_w high every cycle.
//  No transfer in cycle t -> rf_en_w=0 in t+1; rf_waddr/rf_wdata hold last value.
//  Writes to x0: accepted (handshake completes, pointer advances) but rf_en_w=0 in t+1.
//  Requesters must hold valid/addr/data stable until ready; arbiter need not check.
//  Scoreboard: clear: rf_en_w=1 at edge clears pending[rf_waddr]. set: sb_set_en=1 and
//   sb_set_addr!=0 sets pending[sb_set_addr]. Same address set & clear same edge -> set wins.
//   Set of already-pending reg: stays 1 (single outstanding producer per reg is a decode rule).
//  rd_hazard[k] = pending[rd_addrk] (combinational); addr 0 -> 0. Cleared at same edge the
//   regfile commits, so the cycle after the write, read sees new data and no hazard.
//  Reset mid-operation: in-flight registered write is dropped (rf_en_w=0 next cycle), scoreboard cleared.
// STRUCTURE
//  Shared package/defines.v: `ZERO_WORD, GPR count 32, AW=5, requester index constants
//   (WB_ALU=0, WB_LSU=1, WB_CSR=2).
//  One sub-module: ysyx_22051145_rr_arbiter (NREQ valid, ptr in -> one-hot grant, index out), reusable for bus sharing.
//  Scoreboard and output register stay inline in this module.
// TESTING
//  1 Reset: hold rst=0 3 cycles with all req_valid=1 -> req_ready=0, rf_en_w=0, pending=0.
//  2 Single: req0 valid addr=5 data=64'h1234 -> req_ready=3'b001 same cycle; next cycle rf_en_w=1,
//    rf_waddr=5, rf_wdata=64'h1234; cycle after rf_en_w=0.
//  3 Fairness: all three valid continuously, rr_ptr=0 -> grants 001,010,100,001 on successive cycles;
//    rf_en_w high 4 consecutive cycles.
//  4 x0: req1 valid addr=0 -> req_ready[1]=1, next cycle rf_en_w=0, rr_ptr=2.
//  5 Scoreboard: sb_set addr=7 -> pending[7]=1, rd_addr1=7 gives rd_hazard=2'b01; req2 writes x7 ->
//    pending[7]=0 one edge after rf_en_w; set x7 same edge as write to x7 -> pending[7] stays 1.
//  6 Reset mid-op: grant req0 addr=3 then rst=0 next edge -> rf_en_w=0, pending=0, rr_ptr=0.

Source files
------------

// File: rtl/ysyx_22051145_wb_arbiter_pkg.sv
// Shared constants for the GPR writeback path: register file geometry,
// zero word, and the fixed writeback requester slots.
package ysyx_22051145_wb_arbiter_pkg;

  localparam int GPR_NUM = 32;
  localparam int GPR_AW  = 5;
  localparam logic [63:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    WB_ALU = 3'd0,
    WB_LSU = 3'd1,
    WB_CSR = 3'd2
  } wb_src_e;

  // Pointer width for an NREQ-way round-robin (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_22051145_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr (mod NREQ)
// and grants the first valid requester, reporting its index.
module ysyx_22051145_rr_arbiter
  import ysyx_22051145_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && valid[j]) begin
        grant[j] = 1'b1;
        idx      = PW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_22051145_wb_arbiter.sv
// Round-robin sharing of the single GPR write port between writeback sources,
// with a pending-write scoreboard that flags RAW hazards to decode.
module ysyx_22051145_wb_arbiter
  import ysyx_22051145_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = 64,
  parameter int AW   = GPR_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_en_w,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  input  logic                 sb_set_en,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic [AW-1:0]        rd_addr1,
  input  logic [AW-1:0]        rd_addr2,
  output logic [1:0]           rd_hazard,
  output logic [GPR_NUM-1:0]   pending
);

  localparam int PW = ptr_width(NREQ);

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      g_idx;
  logic [NREQ-1:0]    grant;
  logic               g_any;
  logic               xfer;
  logic [AW-1:0]      sel_addr;
  logic [XLEN-1:0]    sel_data;
  logic [PW-1:0]      ptr_nxt;
  logic [GPR_NUM-1:0] pending_nxt;

  ysyx_22051145_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (g_idx),
    .any   (g_any)
  );

  assign req_ready = rst ? grant : '0;
  assign xfer      = rst & g_any;
  assign sel_addr  = req_addr[g_idx*AW +: AW];
  assign sel_data  = req_data[g_idx*XLEN +: XLEN];
  assign ptr_nxt   = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + 1'b1;

  // Clear applies first so a same-edge issue to the committing register re-arms it.
  always_comb begin
    pending_nxt = pending;
    if (rf_en_w) pending_nxt[rf_waddr] = 1'b0;
    if (sb_set_en && (sb_set_addr != '0)) pending_nxt[sb_set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  assign rd_hazard = {pending[rd_addr2], pending[rd_addr1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_en_w  <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rr_ptr   <= '0;
      pending  <= '0;
    end else begin
      pending <= pending_nxt;
      if (xfer) begin
        rf_en_w  <= (sel_addr != '0);
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
        rr_ptr   <= ptr_nxt;
      end else begin
        rf_en_w <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22051145_wb_arbiter.sv
// Directed self-checking bench for the writeback arbiter and scoreboard.
module tb_ysyx_22051145_wb_arbiter;
  import ysyx_22051145_wb_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rf_en_w;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 sb_set_en;
  logic [AW-1:0]        sb_set_addr;
  logic [AW-1:0]        rd_addr1;
  logic [AW-1:0]        rd_addr2;
  logic [1:0]           rd_hazard;
  logic [31:0]          pending;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22051145_wb_arbiter #(
    .NREQ (NREQ),
    .XLEN (XLEN),
    .AW   (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rf_en_w     (rf_en_w),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .rd_hazard   (rd_hazard),
    .pending     (pending)
  );

  // Advance past the next rising edge; registered outputs are then settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [XLEN-1:0] d);
    req_valid[i]           = v;
    req_addr[i*AW +: AW]   = a;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '1;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = '1;
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    rd_addr1 = '0; rd_addr2 = '0;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      $display("FAIL reset_ready_pre: got %b want 000", req_ready); failures++;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (req_ready !== 3'b000) begin
        $display("FAIL reset_ready[%0d]: got %b want 000", c, req_ready); failures++;
      end
      checks++;
      if (rf_en_w !== 1'b0) begin
        $display("FAIL reset_en_w[%0d]: got %b want 0", c, rf_en_w); failures++;
      end
      checks++;
      if (pending !== 32'h0) begin
        $display("FAIL reset_pending[%0d]: got %h want 0", c, pending); failures++;
      end
    end
    req_valid = '0; sb_set_en = 1'b0; sb_set_addr = '0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    set_req(int'(WB_ALU), 1'b1, 5'd5, 64'h1234);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      $display("FAIL single_ready: got %b want 001", req_ready); failures++;
    end
    step();
    req_valid = '0;
    checks++;
    if (rf_en_w !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h1234) begin
      $display("FAIL single_write: got en=%b a=%0d d=%h want en=1 a=5 d=1234",
               rf_en_w, rf_waddr, rf_wdata); failures++;
    end
    step();
    checks++;
    if (rf_en_w !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 64'h1234) begin
      $display("FAIL single_idle_hold: got en=%b a=%0d d=%h want en=0 a=5 d=1234",
               rf_en_w, rf_waddr, rf_wdata); failures++;
    end
  endtask

  // Pointer is 1 here; a lone req2 transfer brings it back to 0 first.
  task automatic test_fairness();
    logic [NREQ-1:0] exp_g [4];
    logic [AW-1:0]   exp_a [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_a = '{5'd1, 5'd2, 5'd3, 5'd1};
    set_req(int'(WB_CSR), 1'b1, 5'd4, 64'hC0);
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      $display("FAIL fair_align_ready: got %b want 100", req_ready); failures++;
    end
    step();
    set_req(int'(WB_ALU), 1'b1, 5'd1, 64'hA);
    set_req(int'(WB_LSU), 1'b1, 5'd2, 64'hB);
    set_req(int'(WB_CSR), 1'b1, 5'd3, 64'hC);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (req_ready !== exp_g[c]) begin
        $display("FAIL fair_grant[%0d]: got %b want %b", c, req_ready, exp_g[c]); failures++;
      end
      step();
      checks++;
      if (rf_en_w !== 1'b1 || rf_waddr !== exp_a[c]) begin
        $display("FAIL fair_write[%0d]: got en=%b a=%0d want en=1 a=%0d",
                 c, rf_en_w, rf_waddr, exp_a[c]); failures++;
      end
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_x0();
    set_req(int'(WB_LSU), 1'b1, 5'd0, 64'hDEAD);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      $display("FAIL x0_ready: got %b want 010", req_ready); failures++;
    end
    step();
    req_valid = '0;
    checks++;
    if (rf_en_w !== 1'b0) begin
      $display("FAIL x0_en_w: got %b want 0", rf_en_w); failures++;
    end
    // Pointer must now be 2: with everyone valid, req2 wins.
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      $display("FAIL x0_ptr_adv: got %b want 100", req_ready); failures++;
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_scoreboard();
    sb_set_en = 1'b1; sb_set_addr = 5'd7;
    rd_addr1 = 5'd7; rd_addr2 = 5'd0;
    step();
    sb_set_en = 1'b0;
    #1;
    checks++;
    if (pending !== 32'h80 || rd_hazard !== 2'b01) begin
      $display("FAIL sb_set: got p=%h h=%b want p=80 h=01", pending, rd_hazard); failures++;
    end
    rd_addr2 = 5'd7;
    #1;
    checks++;
    if (rd_hazard !== 2'b11) begin
      $display("FAIL sb_hazard_both: got %b want 11", rd_hazard); failures++;
    end
    rd_addr2 = 5'd0;
    sb_set_en = 1'b1; sb_set_addr = 5'd0;
    step();
    sb_set_en = 1'b0;
    checks++;
    if (pending !== 32'h80) begin
      $display("FAIL sb_set_x0: got %h want 80", pending); failures++;
    end
    set_req(int'(WB_CSR), 1'b1, 5'd7, 64'h77);
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      $display("FAIL sb_wr_ready: got %b want 100", req_ready); failures++;
    end
    step();
    req_valid = '0;
    checks++;
    if (rf_en_w !== 1'b1 || rf_waddr !== 5'd7 || pending !== 32'h80 || rd_hazard !== 2'b01) begin
      $display("FAIL sb_commit_cycle: got en=%b a=%0d p=%h h=%b want en=1 a=7 p=80 h=01",
               rf_en_w, rf_waddr, pending, rd_hazard); failures++;
    end
    step();
    checks++;
    if (pending !== 32'h0 || rd_hazard !== 2'b00) begin
      $display("FAIL sb_clear: got p=%h h=%b want p=0 h=00", pending, rd_hazard); failures++;
    end
    // Pointer 0: req0 writes x7, and decode re-issues x7 on the commit edge.
    set_req(int'(WB_ALU), 1'b1, 5'd7, 64'h78);
    step();
    req_valid = '0;
    sb_set_en = 1'b1; sb_set_addr = 5'd7;
    checks++;
    if (rf_en_w !== 1'b1 || rf_waddr !== 5'd7) begin
      $display("FAIL sb_race_write: got en=%b a=%0d want en=1 a=7", rf_en_w, rf_waddr); failures++;
    end
    step();
    sb_set_en = 1'b0;
    checks++;
    if (pending !== 32'h80) begin
      $display("FAIL sb_set_wins: got %h want 80", pending); failures++;
    end
    step();
    checks++;
    if (pending !== 32'h80) begin
      $display("FAIL sb_set_holds: got %h want 80", pending); failures++;
    end
  endtask

  // Pointer is 1 here and x7 is still pending.
  task automatic test_reset_midop();
    set_req(int'(WB_ALU), 1'b1, 5'd3, 64'h33);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      $display("FAIL mid_ready: got %b want 001", req_ready); failures++;
    end
    step();
    rst = 1'b0;
    req_valid = '1;
    checks++;
    if (rf_en_w !== 1'b1 || rf_waddr !== 5'd3) begin
      $display("FAIL mid_inflight: got en=%b a=%0d want en=1 a=3", rf_en_w, rf_waddr); failures++;
    end
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      $display("FAIL mid_ready_rst: got %b want 000", req_ready); failures++;
    end
    step();
    checks++;
    if (rf_en_w !== 1'b0 || pending !== 32'h0 || rf_waddr !== 5'd0) begin
      $display("FAIL mid_dropped: got en=%b p=%h a=%0d want en=0 p=0 a=0",
               rf_en_w, pending, rf_waddr); failures++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      $display("FAIL mid_ptr_reset: got %b want 001", req_ready); failures++;
    end
    req_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_x0();
    test_scoreboard();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
